// File: rtl/multi_pushbutton_processor.sv
// multi_pushbutton_processor
// N independent pushbutton channels in the 1 kHz domain. Each channel has a
// 2-FF synchroniser, a press/release debouncer and a short/long press
// classifier with optional auto-repeat of the long-press pulse.
// All outputs come straight from flops; pulses are one cycle wide.

module multi_pushbutton_processor #(
  parameter int N_BUTTONS     = 2,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 2000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_MS     = 250
) (
  input  logic                 clk_1khz,
  input  logic                 rst_i,
  input  logic [N_BUTTONS-1:0] pushbutton_i,
  output logic [N_BUTTONS-1:0] count_up,
  output logic [N_BUTTONS-1:0] count_down,
  output logic [N_BUTTONS-1:0] pressed
);

  localparam int HOLD_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int DEB_W    = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_TGT  = DEB_W'(DEBOUNCE_MS);
  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_TGT = HOLD_W'(LONG_PRESS_MS - 1);
  localparam logic [HOLD_W-1:0] REP_TGT  = HOLD_W'(REPEAT_MS - 1);
  localparam logic              REP_ON   = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_LONG_HELD   = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } state_t;

  // Hold counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    logic [HOLD_W-1:0] r;
    if (v == {HOLD_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + HOLD_W'(1);
    end
    return r;
  endfunction

  logic [N_BUTTONS-1:0] sync1_r;
  logic [N_BUTTONS-1:0] sync2_r;

  // Two-stage synchroniser for the raw asynchronous button levels.
  always_ff @(posedge clk_1khz) begin
    if (!rst_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= pushbutton_i;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    state_t              state_r, state_s;
    logic [DEB_W-1:0]    deb_r, deb_s;
    logic [HOLD_W-1:0]   hold_r, hold_s;
    logic                long_r, long_s;
    logic                pressed_r, pressed_s;
    logic                up_r, up_s;
    logic                down_r, down_s;
    logic                in_s;

    assign in_s = sync2_r[g];

    // Next-state and registered-output decode for one channel.
    always_comb begin
      state_s   = state_r;
      deb_s     = deb_r;
      hold_s    = hold_r;
      long_s    = long_r;
      pressed_s = pressed_r;
      up_s      = 1'b0;
      down_s    = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_s) begin
            state_s = ST_DEB_PRESS;
            deb_s   = DEB_ONE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DEB_PRESS: begin
          if (!in_s) begin
            state_s = ST_IDLE;
          end else if (deb_r == DEB_TGT) begin
            state_s   = ST_PRESSED;
            pressed_s = 1'b1;
            hold_s    = '0;
            long_s    = 1'b0;
          end else begin
            deb_s = deb_r + DEB_ONE;
          end
        end
        ST_PRESSED: begin
          if (!in_s) begin
            state_s = ST_DEB_RELEASE;
            deb_s   = DEB_ONE;
          end else if (hold_r == LONG_TGT) begin
            state_s = ST_LONG_HELD;
            down_s  = 1'b1;
            long_s  = 1'b1;
            hold_s  = '0;
          end else begin
            hold_s = hold_sat_inc(hold_r);
          end
        end
        ST_LONG_HELD: begin
          if (!in_s) begin
            state_s = ST_DEB_RELEASE;
            deb_s   = DEB_ONE;
          end else if (REP_ON) begin
            if (hold_r == REP_TGT) begin
              down_s = 1'b1;
              hold_s = '0;
            end else begin
              hold_s = hold_sat_inc(hold_r);
            end
          end else begin
            hold_s = hold_r;
          end
        end
        ST_DEB_RELEASE: begin
          // hold_r stays frozen here so a release bounce resumes timing.
          if (in_s) begin
            state_s = long_r ? ST_LONG_HELD : ST_PRESSED;
          end else if (deb_r == DEB_TGT) begin
            state_s   = ST_IDLE;
            pressed_s = 1'b0;
            up_s      = ~long_r;
          end else begin
            deb_s = deb_r + DEB_ONE;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          deb_s     = '0;
          hold_s    = '0;
          long_s    = 1'b0;
          pressed_s = 1'b0;
        end
      endcase
    end

    // Channel state and output registers with synchronous reset.
    always_ff @(posedge clk_1khz) begin
      if (!rst_i) begin
        state_r   <= ST_IDLE;
        deb_r     <= '0;
        hold_r    <= '0;
        long_r    <= 1'b0;
        pressed_r <= 1'b0;
        up_r      <= 1'b0;
        down_r    <= 1'b0;
      end else begin
        state_r   <= state_s;
        deb_r     <= deb_s;
        hold_r    <= hold_s;
        long_r    <= long_s;
        pressed_r <= pressed_s;
        up_r      <= up_s;
        down_r    <= down_s;
      end
    end

    assign count_up[g]   = up_r;
    assign count_down[g] = down_r;
    assign pressed[g]    = pressed_r;
  end

endmodule

// File: tb/tb_multi_pushbutton_processor.sv
// Bench for multi_pushbutton_processor: two instances (auto-repeat off / on)
// share the same buttons and are compared every cycle against a run-length
// reference model, plus directed timing checks of the key scenarios.

module tb_multi_pushbutton_processor;

  localparam int DEB  = 20;
  localparam int LONG = 2000;
  localparam int REP  = 250;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [1:0] pb;
  logic [1:0] up0, dn0, pr0, up1, dn1, pr1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  multi_pushbutton_processor #(.N_BUTTONS(2), .DEBOUNCE_MS(DEB), .LONG_PRESS_MS(LONG),
                               .REPEAT_EN(0), .REPEAT_MS(REP)) dut0 (
    .clk_1khz(clk), .rst_i(rst_i), .pushbutton_i(pb),
    .count_up(up0), .count_down(dn0), .pressed(pr0));

  multi_pushbutton_processor #(.N_BUTTONS(2), .DEBOUNCE_MS(DEB), .LONG_PRESS_MS(LONG),
                               .REPEAT_EN(1), .REPEAT_MS(REP)) dut1 (
    .clk_1khz(clk), .rst_i(rst_i), .pushbutton_i(pb),
    .count_up(up1), .count_down(dn1), .pressed(pr1));

  // reference model: [dut][channel]
  bit m_sy1[2], m_sy2[2];
  bit m_lvl[2][2], m_lng[2][2], m_up[2][2], m_dn[2][2];
  int m_run[2][2], m_hold[2][2];

  // observed-event statistics: [dut][channel]
  int n_rise[2][2], n_up[2][2], n_dn[2][2];
  int rise_t[2][2], up_t[2][2], dn_t[2][2];
  bit prev_pr[2][2];
  int dn_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A debounced level flips once the synced input has disagreed with it on
  // DEB+1 consecutive edges; hold time counts steady edges while pressed.
  task automatic model_step(input logic rst_n, input logic [1:0] btn);
    bit s;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_sy1[c] = 1'b0; m_sy2[c] = 1'b0;
        for (int d = 0; d < 2; d++) begin
          m_lvl[d][c] = 1'b0; m_lng[d][c] = 1'b0; m_up[d][c] = 1'b0; m_dn[d][c] = 1'b0;
          m_run[d][c] = 0; m_hold[d][c] = 0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        s = m_sy2[c];
        m_sy2[c] = m_sy1[c];
        m_sy1[c] = btn[c];
        for (int d = 0; d < 2; d++) begin
          m_up[d][c] = 1'b0;
          m_dn[d][c] = 1'b0;
          if (s != m_lvl[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == DEB + 1) begin
              m_run[d][c] = 0;
              if (!m_lvl[d][c]) begin
                m_lvl[d][c] = 1'b1; m_hold[d][c] = 0; m_lng[d][c] = 1'b0;
              end else begin
                m_lvl[d][c] = 1'b0; m_up[d][c] = !m_lng[d][c];
              end
            end
          end else if (m_lvl[d][c] && m_run[d][c] > 0) begin
            m_run[d][c] = 0;   // release bounce: back to held, hold time frozen
          end else if (m_lvl[d][c]) begin
            m_hold[d][c]++;
            if (!m_lng[d][c] && m_hold[d][c] == LONG) begin
              m_dn[d][c] = 1'b1; m_lng[d][c] = 1'b1; m_hold[d][c] = 0;
            end else if (m_lng[d][c] && d == 1 && m_hold[d][c] == REP) begin
              m_dn[d][c] = 1'b1; m_hold[d][c] = 0;
            end
          end else begin
            m_run[d][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic clr_stats();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        n_rise[d][c] = 0; n_up[d][c] = 0; n_dn[d][c] = 0;
        rise_t[d][c] = -1; up_t[d][c] = -1; dn_t[d][c] = -1;
      end
    dn_q.delete();
  endtask

  task automatic tick();
    logic [1:0] ov_pr[2], ov_up[2], ov_dn[2];
    @(posedge clk);
    cyc++;
    model_step(rst_i, pb);
    #1;
    ov_pr[0] = pr0; ov_up[0] = up0; ov_dn[0] = dn0;
    ov_pr[1] = pr1; ov_up[1] = up1; ov_dn[1] = dn1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("cyc%0d_d%0d_pressed", cyc, d), 32'(ov_pr[d]), 32'({m_lvl[d][1], m_lvl[d][0]}));
      check($sformatf("cyc%0d_d%0d_up", cyc, d), 32'(ov_up[d]), 32'({m_up[d][1], m_up[d][0]}));
      check($sformatf("cyc%0d_d%0d_down", cyc, d), 32'(ov_dn[d]), 32'({m_dn[d][1], m_dn[d][0]}));
      for (int c = 0; c < 2; c++) begin
        if (ov_pr[d][c] === 1'b1 && !prev_pr[d][c]) begin n_rise[d][c]++; rise_t[d][c] = cyc; end
        prev_pr[d][c] = (ov_pr[d][c] === 1'b1);
        if (ov_up[d][c] === 1'b1) begin n_up[d][c]++; up_t[d][c] = cyc; end
        if (ov_dn[d][c] === 1'b1) begin
          n_dn[d][c]++; dn_t[d][c] = cyc;
          if (d == 1 && c == 0) dn_q.push_back(cyc);
        end
      end
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int q_at(input int i);
    return (dn_q.size() > i) ? dn_q[i] : -1;
  endfunction

  initial begin
    int edge_t, rel_t, rst_edge;
    int rem[2];
    logic [1:0] lv;
    int sel;

    pb = 2'b00; rst_i = 1'b0;
    clr_stats();
    for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) prev_pr[d][c] = 1'b0;

    // reset state
    hold(2);
    check("reset_state", 32'({pr0, up0, dn0, pr1, up1, dn1}), 32'd0);
    rst_i = 1'b1;
    hold(5);

    // 1: bouncy short press on ch0
    clr_stats();
    pb[0] = 1'b1; hold(2); pb[0] = 1'b0; hold(1);
    pb[0] = 1'b1; hold(2); pb[0] = 1'b0; hold(1);
    pb[0] = 1'b1; edge_t = cyc + 1; hold(30);
    pb[0] = 1'b0; rel_t = cyc + 1; hold(40);
    check("t1_press_lat", 32'(rise_t[0][0] - edge_t), 32'd22);
    check("t1_rise_cnt", 32'(n_rise[0][0]), 32'd1);
    check("t1_up_cnt", 32'(n_up[0][0]), 32'd1);
    check("t1_up_lat", 32'(up_t[0][0] - rel_t), 32'd22);
    check("t1_down_cnt", 32'(n_dn[0][0] + n_dn[1][0]), 32'd0);
    check("t1_ch1_quiet", 32'(n_rise[0][1] + n_up[0][1] + n_dn[0][1]), 32'd0);

    // 2: ch1 glitch shorter than the debounce window
    clr_stats();
    pb[1] = 1'b1; hold(15); pb[1] = 1'b0; hold(40);
    check("t2_ch1_quiet", 32'(n_rise[0][1] + n_up[0][1] + n_dn[0][1]), 32'd0);

    // 3: long press with release bounce
    clr_stats();
    pb[0] = 1'b1; hold(2100);
    pb[0] = 1'b0; hold(2); pb[0] = 1'b1; hold(2); pb[0] = 1'b0; hold(40);
    check("t3_down_cnt", 32'(n_dn[0][0]), 32'd1);
    check("t3_down_lat", 32'(dn_t[0][0] - rise_t[0][0]), 32'd2000);
    check("t3_up_cnt", 32'(n_up[0][0] + n_up[1][0]), 32'd0);
    check("t3_rep_down_cnt", 32'(n_dn[1][0]), 32'd1);
    check("t3_released", 32'(pr0[0]), 32'd0);

    // 4: long hold, repeat instance re-pulses
    clr_stats();
    pb[0] = 1'b1; hold(2600); pb[0] = 1'b0; hold(40);
    check("t4_rep_cnt", 32'(dn_q.size()), 32'd3);
    check("t4_rep0", 32'(q_at(0) - rise_t[1][0]), 32'd2000);
    check("t4_rep1", 32'(q_at(1) - rise_t[1][0]), 32'd2250);
    check("t4_rep2", 32'(q_at(2) - rise_t[1][0]), 32'd2500);
    check("t4_norep_cnt", 32'(n_dn[0][0]), 32'd1);
    check("t4_up_cnt", 32'(n_up[1][0]), 32'd0);

    // 5: both channels short press together
    clr_stats();
    pb = 2'b11; hold(40); pb = 2'b00; hold(40);
    check("t5_up_ch0", 32'(n_up[0][0]), 32'd1);
    check("t5_up_ch1", 32'(n_up[0][1]), 32'd1);
    check("t5_same_cycle", 32'(up_t[0][0] - up_t[0][1]), 32'd0);

    // 6: reset pulse in the middle of a hold
    pb[0] = 1'b1; hold(1000);
    rst_i = 1'b0; rst_edge = cyc + 1; tick();
    check("t6_rst_out", 32'({pr0, up0, dn0, pr1, up1, dn1}), 32'd0);
    rst_i = 1'b1;
    clr_stats();
    hold(499);
    pb[0] = 1'b0; rel_t = cyc + 1; hold(40);
    check("t6_rerise_lat", 32'(rise_t[0][0] - (rst_edge + 1)), 32'd22);
    check("t6_up_cnt", 32'(n_up[0][0]), 32'd1);
    check("t6_up_lat", 32'(up_t[0][0] - rel_t), 32'd22);
    check("t6_down_cnt", 32'(n_dn[0][0] + n_dn[1][0]), 32'd0);

    // random phase: bounces, near-threshold pulses, long holds, rare resets
    rem[0] = 0; rem[1] = 0; lv = 2'b00; pb = 2'b00;
    for (int i = 0; i < 8000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lv[c] = ~lv[c];
          sel = int'($urandom_range(0, 9));
          if (sel < 4)       rem[c] = int'($urandom_range(1, 3));
          else if (sel < 8)  rem[c] = int'($urandom_range(15, 60));
          else if (sel == 8) rem[c] = lv[c] ? int'($urandom_range(1990, 2300)) : 30;
          else               rem[c] = int'($urandom_range(18, 25));
        end
        rem[c]--;
      end
      pb = lv;
      rst_i = ($urandom_range(0, 1999) != 0);
      tick();
    end
    rst_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
